// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide pipelined RAM port, shared between IF fetches and MEM loads/stores.
// Define ARB_RR_EN for round-robin arbitration; without it MEM has fixed priority over IF.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din_ram,
    output logic [7:0]        dout_ram,
    output logic [ADDR_W-1:0] addr_ram,
    output logic              wr_ram,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata
);

`ifdef ARB_RR_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    // Handshake: a req is a level held until its one-cycle done pulse (IF may instead abort with
    // if_flush); no grant is made while either done is high, and requester inputs are latched at grant.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

    state_t            state, state_next;
    logic              owner_mem, last_mem, primed;
    logic [2:0]        n_bytes, issue_cnt, recv_cnt, mem_n;
    logic [DATA_W-1:0] wdata_q, acc, acc_next;
    logic              if_ok, mem_wins, arb_ok, grant_mem, grant_if;
    logic              issue_more, read_last, flush_abort, write_fin;

    always_comb begin
        mem_n = 3'd4;
        case (mem_size)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
        if_ok       = if_req && !if_flush;
        arb_ok      = (state == IDLE) && !if_done && !mem_done;
        mem_wins    = mem_req && (!RoundRobin || !if_ok || !last_mem);
        grant_mem   = arb_ok && mem_wins;
        grant_if    = arb_ok && if_ok && !mem_wins;
        issue_more  = issue_cnt < n_bytes;
        flush_abort = (state == READ) && !owner_mem && if_flush;
        // The first received byte arrives two edges after its address was driven.
        read_last   = (state == READ) && primed && (recv_cnt == n_bytes - 3'd1);
        write_fin   = (state == WRITE) && !issue_more;
        acc_next    = acc | (DATA_W'(din_ram) << {recv_cnt, 3'b000});
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_mem)     state_next = mem_we ? WRITE : READ;
                else if (grant_if) state_next = READ;
            end
            READ:    if (flush_abort || read_last) state_next = IDLE;
            WRITE:   if (write_fin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_ram  <= '0;
            addr_ram  <= '0;
            wr_ram    <= 1'b0;
            if_done   <= 1'b0;
            if_data   <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            owner_mem <= 1'b0;
            last_mem  <= 1'b0;
            n_bytes   <= '0;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            primed    <= 1'b0;
            wdata_q   <= '0;
            acc       <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (grant_mem || grant_if) begin
                owner_mem <= grant_mem;
                last_mem  <= grant_mem;
                n_bytes   <= grant_mem ? mem_n : 3'd4;
                addr_ram  <= grant_mem ? mem_addr : if_addr;
                wr_ram    <= grant_mem && mem_we;
                if (grant_mem && mem_we) dout_ram <= mem_wdata[7:0];
                wdata_q   <= mem_wdata;
                issue_cnt <= 3'd1;
                recv_cnt  <= '0;
                primed    <= 1'b0;
                acc       <= '0;
            end else if (state == WRITE) begin
                if (issue_more) begin
                    addr_ram  <= addr_ram + ADDR_W'(1);
                    dout_ram  <= wdata_q[{issue_cnt[1:0], 3'b000} +: 8];
                    issue_cnt <= issue_cnt + 3'd1;
                end else begin
                    wr_ram   <= 1'b0;
                    mem_done <= 1'b1;
                end
            end else if (state == READ && !flush_abort) begin
                if (issue_more) begin
                    addr_ram  <= addr_ram + ADDR_W'(1);
                    issue_cnt <= issue_cnt + 3'd1;
                end
                primed <= 1'b1;
                if (primed) begin
                    acc      <= acc_next;
                    recv_cnt <= recv_cnt + 3'd1;
                    if (read_last) begin
                        if (owner_mem) begin
                            mem_rdata <= acc_next;
                            mem_done  <= 1'b1;
                        end else begin
                            if_data <= acc_next;
                            if_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
